// File: rtl/tick_scheduler.sv
// tick_scheduler: one shared prescaler feeding NUM_CH one-shot/periodic countdown channels
// clock/reset: posedge clock, sync active-high reset
// prescale: live divide value; pre_tick pulses every prescale+1 cycles
// cfg_valid/cfg_ready/cfg_ch/cfg_mode/cfg_period: channel write port (mode 01 one-shot, 10 periodic, else stop)
// pre_tick: shared tick; ch_fire: registered per-channel fire pulse; ch_busy: channel running
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PRE_WIDTH = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  output logic                 pre_tick,
  output logic [NUM_CH-1:0]    ch_fire,
  output logic [NUM_CH-1:0]    ch_busy
);
  typedef enum logic [1:0] {IDLE, ONESHOT, PERIODIC} state_e;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                 ready_q;
  state_e               state_q [NUM_CH];
  state_e               state_d [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] period_q [NUM_CH];
  logic [CNT_WIDTH-1:0] period_d [NUM_CH];
  logic [NUM_CH-1:0]    fire_q, fire_d, busy_q, busy_d, hit, arm, go;
  logic                 wr;
  assign pre_tick = pre_cnt_q >= prescale;
  assign cfg_ready = ready_q;
  assign ch_fire = fire_q;
  assign ch_busy = busy_q;
  // Out-of-range cfg_ch values match no channel, so such writes are accepted and dropped.
  // A write to a channel shadows that channel's pre_tick evaluation in the same cycle.
  always_comb begin
    pre_cnt_d = pre_tick ? '0 : pre_cnt_q + 1'b1;
    wr = cfg_valid & ready_q;
    hit = '0;
    arm = '0;
    go = '0;
    fire_d = '0;
    busy_d = '0;
    state_d = state_q;
    cnt_d = cnt_q;
    period_d = period_q;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = wr && (cfg_ch == CH_W'(i));
      arm[i] = hit[i] && (cfg_mode == 2'b01 || cfg_mode == 2'b10);
      go[i] = !hit[i] && pre_tick && state_q[i] != IDLE;
      fire_d[i] = go[i] && cnt_q[i] == '0;
      period_d[i] = arm[i] ? cfg_period : period_q[i];
      cnt_d[i] = arm[i] ? cfg_period : !go[i] ? cnt_q[i] : fire_d[i] ? period_q[i] : cnt_q[i] - 1'b1;
      state_d[i] = arm[i] ? (cfg_mode[0] ? ONESHOT : PERIODIC) :
                   hit[i] ? IDLE :
                   (fire_d[i] && state_q[i] == ONESHOT) ? IDLE : state_q[i];
      busy_d[i] = state_d[i] != IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_q <= '0;
      ready_q <= 1'b0;
      fire_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i] <= '0;
        period_q[i] <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      ready_q <= 1'b1;
      fire_q <= fire_d;
      busy_q <= busy_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
    end
  end
endmodule
